// File: rtl/furnace_pkg.sv
// Shared types and constants for the furnace operator and its helpers.
package furnace_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEAT,
    LOAD,
    BAKE,
    UNLOAD,
    DONE,
    FAULT
  } op_state_t;

  localparam int TEMP_W = 7;
  localparam int CNT_W  = 8;

  localparam logic [TEMP_W-1:0] TEMP_FLOOR = 7'd25;
  localparam logic [TEMP_W-1:0] TEMP_CEIL  = 7'd120;

  // Phases that advance the shared phase counter every cycle.
  function automatic logic is_timed(op_state_t s);
    return (s == HEAT) || (s == LOAD) || (s == BAKE) || (s == UNLOAD);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Shared phase counter: clears on request, otherwise counts while enabled,
// and flags when it has reached the caller's runtime limit.
module phase_timer
  import furnace_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == limit);

endmodule

// File: rtl/furnace_operator.sv
// Closed-loop bake-job sequencer: heat, load, bake, unload, with a sticky
// fault on alarm or heat timeout. All outputs are registered.
module furnace_operator
  import furnace_pkg::*;
#(
  parameter logic [TEMP_W-1:0] TARGET_TEMP  = 7'd100,
  parameter int                LOAD_CYCLES  = 4,
  parameter int                BAKE_CYCLES  = 20,
  parameter int                HEAT_TIMEOUT = 63
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              job_req,
  input  logic              fault_clr,
  input  logic [TEMP_W-1:0] furnace_temp,
  input  logic              alarm,
  output logic              door_sig,
  output logic              usage,
  output logic              job_ack,
  output logic              job_done,
  output logic              fault,
  output logic              busy,
  output logic [7:0]        jobs_cnt
);

  if (TARGET_TEMP <= TEMP_FLOOR || TARGET_TEMP > TEMP_CEIL) begin : g_bad_target
    $error("furnace_operator: TARGET_TEMP outside the reachable furnace range");
  end
  if (LOAD_CYCLES < 1 || LOAD_CYCLES > 256) begin : g_bad_load
    $error("furnace_operator: LOAD_CYCLES must be 1..256");
  end
  if (BAKE_CYCLES < 1 || BAKE_CYCLES > 256) begin : g_bad_bake
    $error("furnace_operator: BAKE_CYCLES must be 1..256");
  end
  if (HEAT_TIMEOUT < 1 || HEAT_TIMEOUT > 256) begin : g_bad_heat
    $error("furnace_operator: HEAT_TIMEOUT must be 1..256");
  end

  localparam logic [CNT_W-1:0] LOAD_LIM = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BAKE_LIM = CNT_W'(BAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HEAT_LIM = CNT_W'(HEAT_TIMEOUT - 1);

  op_state_t        state;
  logic             hot;
  logic             expired;
  logic             phase_end;
  logic             timed;
  logic [CNT_W-1:0] limit;

  // furnace_temp is stable at posedge (furnace updates on negedge), so no sync.
  assign hot   = (furnace_temp >= TARGET_TEMP);
  assign timed = is_timed(state);

  always_comb begin
    limit = '0;
    case (state)
      HEAT:         limit = HEAT_LIM;
      LOAD, UNLOAD: limit = LOAD_LIM;
      BAKE:         limit = BAKE_LIM;
      default:      limit = '0;
    endcase
  end

  // Any exit from the current phase restarts the counter for the next one.
  assign phase_end = expired
                   | ((state == HEAT) & hot)
                   | (((state == LOAD) | (state == UNLOAD)) & alarm);

  phase_timer u_phase_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (~timed | phase_end),
    .inc     (timed),
    .limit   (limit),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      door_sig <= 1'b0;
      usage    <= 1'b0;
      job_ack  <= 1'b0;
      job_done <= 1'b0;
      fault    <= 1'b0;
      busy     <= 1'b0;
      jobs_cnt <= 8'd0;
    end else begin
      job_ack  <= 1'b0;
      job_done <= 1'b0;
      case (state)
        IDLE: begin
          if (job_req) begin
            state   <= HEAT;
            job_ack <= 1'b1;
            busy    <= 1'b1;
          end
        end
        HEAT: begin
          if (hot) begin
            state    <= LOAD;
            door_sig <= 1'b1;
            usage    <= 1'b1;
          end else if (expired) begin
            state <= FAULT;
            fault <= 1'b1;
            busy  <= 1'b0;
          end
        end
        LOAD: begin
          if (alarm) begin
            state    <= FAULT;
            fault    <= 1'b1;
            busy     <= 1'b0;
            door_sig <= 1'b0;
            usage    <= 1'b0;
          end else if (expired) begin
            state    <= BAKE;
            door_sig <= 1'b0;
          end
        end
        BAKE: begin
          // Alarm is deliberately ignored while the door is shut and baking.
          if (expired) begin
            state    <= UNLOAD;
            door_sig <= 1'b1;
          end
        end
        UNLOAD: begin
          if (alarm) begin
            state    <= FAULT;
            fault    <= 1'b1;
            busy     <= 1'b0;
            door_sig <= 1'b0;
            usage    <= 1'b0;
          end else if (expired) begin
            state    <= DONE;
            door_sig <= 1'b0;
            usage    <= 1'b0;
            job_done <= 1'b1;
            jobs_cnt <= jobs_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        FAULT: begin
          if (fault_clr) begin
            state <= IDLE;
            fault <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          door_sig <= 1'b0;
          usage    <= 1'b0;
          fault    <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_furnace_operator.sv
// Bench for furnace_operator: three differently parameterised instances
// checked every cycle against a phase/remaining-cycles model.
module tb_furnace_operator;

  localparam int M_IDLE   = 0;
  localparam int M_HEAT   = 1;
  localparam int M_LOAD   = 2;
  localparam int M_BAKE   = 3;
  localparam int M_UNLOAD = 4;
  localparam int M_DONE   = 5;
  localparam int M_FAULT  = 6;

  localparam int P_TGT  [3] = '{100, 100, 30};
  localparam int P_LOAD [3] = '{4, 4, 40};
  localparam int P_BAKE [3] = '{20, 20, 20};
  localparam int P_HEAT [3] = '{63, 3, 63};

  typedef struct {
    int ph;
    int left;
    int jobs;
    bit ack;
    bit done;
  } model_t;

  logic       clock;
  logic [2:0] rst_n;
  logic [2:0] job_req;
  logic [2:0] fault_clr;
  logic [2:0] alarm;
  logic [6:0] temp [3];
  logic [2:0] door_sig, usage, job_ack, job_done, fault, busy;
  logic [7:0] jobs_cnt [3];

  model_t mdl [3];
  int checks = 0;
  int errors = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  furnace_operator u_dut0 (
    .clock(clock), .reset_n(rst_n[0]), .job_req(job_req[0]), .fault_clr(fault_clr[0]),
    .furnace_temp(temp[0]), .alarm(alarm[0]), .door_sig(door_sig[0]), .usage(usage[0]),
    .job_ack(job_ack[0]), .job_done(job_done[0]), .fault(fault[0]), .busy(busy[0]),
    .jobs_cnt(jobs_cnt[0])
  );

  furnace_operator #(.HEAT_TIMEOUT(3)) u_dut1 (
    .clock(clock), .reset_n(rst_n[1]), .job_req(job_req[1]), .fault_clr(fault_clr[1]),
    .furnace_temp(temp[1]), .alarm(alarm[1]), .door_sig(door_sig[1]), .usage(usage[1]),
    .job_ack(job_ack[1]), .job_done(job_done[1]), .fault(fault[1]), .busy(busy[1]),
    .jobs_cnt(jobs_cnt[1])
  );

  furnace_operator #(.TARGET_TEMP(7'd30), .LOAD_CYCLES(40)) u_dut2 (
    .clock(clock), .reset_n(rst_n[2]), .job_req(job_req[2]), .fault_clr(fault_clr[2]),
    .furnace_temp(temp[2]), .alarm(alarm[2]), .door_sig(door_sig[2]), .usage(usage[2]),
    .job_ack(job_ack[2]), .job_done(job_done[2]), .fault(fault[2]), .busy(busy[2]),
    .jobs_cnt(jobs_cnt[2])
  );

  function automatic model_t mreset();
    model_t r;
    r.ph = M_IDLE; r.left = 0; r.jobs = 0; r.ack = 0; r.done = 0;
    return r;
  endfunction

  // One clock edge of the job rules: each phase lasts "left" more cycles.
  function automatic model_t step(model_t m, int u, logic rst, logic req, logic clr,
                                  logic [6:0] t, logic al);
    model_t n = m;
    n.ack  = 0;
    n.done = 0;
    if (!rst) return mreset();
    case (m.ph)
      M_IDLE:  if (req) begin n.ph = M_HEAT; n.left = P_HEAT[u]; n.ack = 1; end
      M_HEAT: begin
        if (int'(t) >= P_TGT[u]) begin n.ph = M_LOAD; n.left = P_LOAD[u]; end
        else if (m.left == 1) n.ph = M_FAULT;
        else n.left = m.left - 1;
      end
      M_LOAD: begin
        if (al) n.ph = M_FAULT;
        else if (m.left == 1) begin n.ph = M_BAKE; n.left = P_BAKE[u]; end
        else n.left = m.left - 1;
      end
      M_BAKE: begin
        if (m.left == 1) begin n.ph = M_UNLOAD; n.left = P_LOAD[u]; end
        else n.left = m.left - 1;
      end
      M_UNLOAD: begin
        if (al) n.ph = M_FAULT;
        else if (m.left == 1) begin n.ph = M_DONE; n.done = 1; n.jobs = (m.jobs + 1) % 256; end
        else n.left = m.left - 1;
      end
      M_DONE:  n.ph = M_IDLE;
      default: if (clr) n.ph = M_IDLE;
    endcase
    return n;
  endfunction

  task automatic chk(input string name, input int u, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s unit%0d at %0t: got %0d expected %0d", name, u, $time, act, exp);
    end
  endtask

  // Advance one cycle: model sees the inputs the DUT saw at the posedge.
  task automatic tick();
    @(negedge clock);
    for (int u = 0; u < 3; u++) begin
      mdl[u] = step(mdl[u], u, rst_n[u], job_req[u], fault_clr[u], temp[u], alarm[u]);
      chk("door_sig", u, door_sig[u], int'(mdl[u].ph == M_LOAD || mdl[u].ph == M_UNLOAD));
      chk("usage", u, usage[u],
          int'(mdl[u].ph == M_LOAD || mdl[u].ph == M_BAKE || mdl[u].ph == M_UNLOAD));
      chk("busy", u, busy[u], int'(mdl[u].ph != M_IDLE && mdl[u].ph != M_FAULT));
      chk("fault", u, fault[u], int'(mdl[u].ph == M_FAULT));
      chk("job_ack", u, job_ack[u], int'(mdl[u].ack));
      chk("job_done", u, job_done[u], int'(mdl[u].done));
      chk("jobs_cnt", u, int'(jobs_cnt[u]), mdl[u].jobs);
    end
  endtask

  task automatic run0(input int n, input int pa, input int pb, input int ab,
                      output int heat_n, output int open_n, output int bake_n,
                      output int done_n, output int ack_n);
    heat_n = 0; open_n = 0; bake_n = 0; done_n = 0; ack_n = 0;
    for (int i = 0; i < n; i++) begin
      if (temp[0] < 7'd100) temp[0] = temp[0] + 7'd5;
      job_req[0] = (i == pa) || (i == pb);
      alarm[0]   = (i == ab);
      tick();
      ack_n  += int'(job_ack[0]);
      done_n += int'(job_done[0]);
      open_n += int'(door_sig[0]);
      bake_n += int'(usage[0] & ~door_sig[0]);
      heat_n += int'(busy[0] & ~usage[0] & ~job_done[0]);
    end
    job_req[0] = 1'b0;
    alarm[0]   = 1'b0;
  endtask

  initial begin
    int h, o, b, d, a;
    rst_n = '0; job_req = '0; fault_clr = '0; alarm = '0;
    temp[0] = 7'd50; temp[1] = 7'd50; temp[2] = 7'd28;
    for (int u = 0; u < 3; u++) mdl[u] = mreset();
    repeat (3) tick();
    chk("reset_jobs_cnt", 0, int'(jobs_cnt[0]), 0);
    chk("reset_outputs", 1, int'({door_sig[1], usage[1], busy[1], fault[1]}), 0);
    rst_n = '1;
    tick();

    // Nominal job from 50 degrees, ramping 5 per cycle.
    run0(60, 0, -1, -1, h, o, b, d, a);
    chk("nom_ack", 0, a, 1);
    chk("nom_heat_cycles", 0, h, 9);
    chk("nom_open_cycles", 0, o, 8);
    chk("nom_bake_cycles", 0, b, 20);
    chk("nom_done", 0, d, 1);
    chk("nom_jobs_cnt", 0, int'(jobs_cnt[0]), 1);

    // Hot furnace; request during BAKE rejected, alarm during BAKE ignored.
    run0(40, 0, 15, 10, h, o, b, d, a);
    chk("busy_ack", 0, a, 1);
    chk("busy_heat_cycles", 0, h, 1);
    chk("busy_open_cycles", 0, o, 8);
    chk("busy_bake_cycles", 0, b, 20);
    chk("busy_jobs_cnt", 0, int'(jobs_cnt[0]), 2);

    // Reset mid-LOAD acts without a clock edge.
    job_req[0] = 1'b1;
    tick();
    job_req[0] = 1'b0;
    repeat (2) tick();
    chk("load_door", 0, int'(door_sig[0]), 1);
    #3 rst_n[0] = 1'b0;
    #1;
    mdl[0] = mreset();
    chk("rst_door", 0, int'(door_sig[0]), 0);
    chk("rst_usage", 0, int'(usage[0]), 0);
    chk("rst_jobs_cnt", 0, int'(jobs_cnt[0]), 0);
    tick();
    rst_n[0] = 1'b1;
    tick();
    chk("rst_idle", 0, int'(busy[0]), 0);

    // Heat timeout on unit 1 (limit 3, temp stuck at 50).
    job_req[1] = 1'b1;
    tick();
    job_req[1] = 1'b0;
    repeat (2) tick();
    chk("to_busy", 1, int'(busy[1]), 1);
    chk("to_no_fault_yet", 1, int'(fault[1]), 0);
    tick();
    chk("to_fault", 1, int'(fault[1]), 1);
    chk("to_door", 1, int'(door_sig[1]), 0);
    fault_clr[1] = 1'b1; job_req[1] = 1'b1;
    tick();
    chk("to_clr_no_ack", 1, int'(job_ack[1]), 0);
    chk("to_clr_fault", 1, int'(fault[1]), 0);
    tick();
    chk("to_held_req_ack", 1, int'(job_ack[1]), 1);
    fault_clr[1] = 1'b0; job_req[1] = 1'b0;
    repeat (5) tick();

    // Alarm during a long LOAD on unit 2.
    job_req[2] = 1'b1;
    tick();
    job_req[2] = 1'b0; temp[2] = 7'd30;
    tick();
    chk("al_load_door", 2, int'(door_sig[2]), 1);
    fault_clr[2] = 1'b1;
    tick();
    fault_clr[2] = 1'b0;
    repeat (5) tick();
    temp[2] = 7'd25; alarm[2] = 1'b1;
    tick();
    alarm[2] = 1'b0;
    chk("al_fault", 2, int'(fault[2]), 1);
    chk("al_door", 2, int'(door_sig[2]), 0);
    fault_clr[2] = 1'b1; job_req[2] = 1'b1;
    tick();
    chk("al_clr_no_ack", 2, int'(job_ack[2]), 0);
    chk("al_clr_idle", 2, int'(busy[2]), 0);
    fault_clr[2] = 1'b0; job_req[2] = 1'b0;
    tick();

    // 256 back-to-back jobs with job_req held high.
    temp[0] = 7'd100;
    job_req[0] = 1'b1;
    d = 0;
    for (int i = 0; i < 9000 && d < 256; i++) begin
      tick();
      d += int'(job_done[0]);
    end
    job_req[0] = 1'b0;
    chk("wrap_done_pulses", 0, d, 256);
    chk("wrap_jobs_cnt", 0, int'(jobs_cnt[0]), 0);
    repeat (3) tick();
    chk("wrap_idle", 0, int'(busy[0]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/furnace_operator.md
# furnace_operator

Closed-loop controller that drives the furnace model's `door_sig`/`usage` inputs from its `furnace_temp`/`alarm` outputs. Accepts one bake job at a time over a req/ack handshake and sequences it through heat-up, load, bake and unload. Aborts to a sticky fault on alarm or heat timeout. Sits between the job scheduler (upstream) and the `furnace` block (downstream), sharing its single clock.

## Interface
- `TARGET_TEMP`, 7'd100: minimum `furnace_temp` before loading; legal range 26..120.
- `LOAD_CYCLES`, 4: cycles the door stays open for load, and again for unload; ≥1.
- `BAKE_CYCLES`, 20: cycles the door stays closed with `usage`=1; ≥1.
- `HEAT_TIMEOUT`, 63: maximum cycles in HEAT before fault; ≥1.
- `clock` in 1: system clock; all state updates on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `job_req` in 1: level request for a new job.
- `fault_clr` in 1: clears the sticky fault.
- `furnace_temp` in 7: furnace temperature, unsigned.
- `alarm` in 1: furnace alarm.
- `door_sig` out 1: 1 = door open.
- `usage` out 1: 1 = furnace in use.
- `job_ack` out 1: one-cycle pulse when a job is accepted.
- `job_done` out 1: one-cycle pulse when a job completes.
- `fault` out 1: sticky fault flag.
- `busy` out 1: high in every state except IDLE and FAULT.
- `jobs_cnt` out 8: count of completed jobs; wraps 255→0.

## Operation
- **Reset values.** All outputs 0, `jobs_cnt`=0, state IDLE, phase counter 0.
- **Outputs are registered.** `door_sig`/`usage` per state:
  - IDLE, HEAT, DONE, FAULT: 0/0.
  - LOAD, UNLOAD: 1/1.
  - BAKE: 0/1.
- **IDLE.** If `job_req`=1: pulse `job_ack`, load counter 0, go to HEAT. Otherwise stay.
- **HEAT.** If `furnace_temp` ≥ `TARGET_TEMP`, go to LOAD with counter 0. Otherwise, when the counter reaches `HEAT_TIMEOUT`-1, go to FAULT.
  - The temperature check has priority over the timeout in the same cycle.
- **LOAD.** If `alarm`=1, go to FAULT. Otherwise, when the counter reaches `LOAD_CYCLES`-1, go to BAKE.
- **BAKE.** `alarm` is ignored. When the counter reaches `BAKE_CYCLES`-1, go to UNLOAD.
- **UNLOAD.** If `alarm`=1, go to FAULT. Otherwise, when the counter reaches `LOAD_CYCLES`-1, go to DONE.
  - In LOAD and UNLOAD, alarm has priority over counter expiry.
- **DONE.** One cycle: pulse `job_done`, increment `jobs_cnt`, go to IDLE.
- **FAULT.** `fault`=1 (set on entry). Stays until `fault_clr`=1, then `fault`←0 and go to IDLE.
  - `job_req` in the same cycle as `fault_clr` is not accepted.
- **Handshake.** `job_req` outside IDLE is ignored: no ack, no queueing. A requester holding `job_req` high gets a new ack one cycle after DONE, i.e. in IDLE.
- **Counter.** One shared counter of 8 bits. It resets to 0 on every state entry and increments every cycle in HEAT/LOAD/BAKE/UNLOAD.
- **Comparisons.** `furnace_temp` and `TARGET_TEMP` are compared as 7-bit unsigned.
- **`fault_clr` outside FAULT** has no effect.
- **Reset mid-job.** Asserting `reset_n`=0 in any state forces door closed and `usage`=0 asynchronously. No `job_done` is produced and `jobs_cnt` is cleared.

## Timing
- Registered outputs change on posedge `clock`. The furnace updates on negedge, so `furnace_temp`/`alarm` are stable at each posedge and are used without synchronisers.
- Accept latency: `job_req` sampled at posedge N → `job_ack`=1 during cycle N..N+1 and state HEAT from N+1.
- Phase durations, in cycles:
  - LOAD: exactly `LOAD_CYCLES`.
  - BAKE: exactly `BAKE_CYCLES`.
  - UNLOAD: exactly `LOAD_CYCLES`.
  - DONE: 1.
  - HEAT: between 1 and `HEAT_TIMEOUT`.
- Minimum job length from ack to `job_done`: 1 + 2·`LOAD_CYCLES` + `BAKE_CYCLES` + 1 cycles.
- Alarm abort: `alarm` seen at posedge N → FAULT, door closed, from N+1.

## Structure
- Shared package `furnace_pkg`:
  - state enum `op_state_t` {IDLE, HEAT, LOAD, BAKE, UNLOAD, DONE, FAULT};
  - `TEMP_W`=7;
  - `TEMP_FLOOR`=25 and `TEMP_CEIL`=120 constants.
- One natural sub-module, `phase_timer`: 8-bit clear/increment counter with an `expired` compare against a runtime limit input.

## Test plan
- **Nominal job.** Reset, furnace at 50, pulse `job_req`. Required:
  - `job_ack` next cycle;
  - LOAD entered about 10 cycles later at temp ≥100;
  - door open for 4 cycles, closed with `usage`=1 for 20 cycles, open for 4 cycles;
  - `job_done` pulse and `jobs_cnt`=1.
- **Heat timeout.** `HEAT_TIMEOUT`=3, `furnace_temp` held at 50 by the bench → FAULT after 3 cycles, `fault`=1, door 0.
- **Alarm during load.** `LOAD_CYCLES`=40, `TARGET_TEMP`=30 → temp floors at 25, alarm rises, FAULT the next cycle. `fault_clr` → IDLE; a simultaneous `job_req` gets no ack.
- **Busy rejection.** `job_req` pulsed during BAKE → no `job_ack`, job runs unchanged.
- **Reset mid-job.** `reset_n`=0 during LOAD → `door_sig`=0 and `usage`=0 immediately, without waiting for a clock edge; `jobs_cnt`=0; state IDLE after release.
- **Wrap.** 256 back-to-back jobs with `job_req` held high → `jobs_cnt` wraps to 0 and exactly 256 `job_done` pulses are seen.
